// File: rtl/exec_alu_stage.sv
// Execute-stage sequencer: decodes ops into ALU control words, registers the ALU result in a
// one-entry output slot, and keeps the condition-code register and a saturation event counter.
`timescale 1ns/1ps
module exec_alu_stage #(
  parameter int unsigned W        = 16,
  parameter int unsigned SATCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [W-1:0]        in_a,
  input  logic [W-1:0]        in_b,
  input  logic                flush,
  output logic [W-1:0]        alu_A,
  output logic [W-1:0]        alu_B,
  output logic [3:0]          alu_Sigs,
  input  logic [W-1:0]        alu_D,
  input  logic                alu_Vl,
  input  logic                alu_Vh,
  input  logic                alu_Z,
  input  logic                alu_N,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic                out_err,
  output logic [2:0]          ccr,
  output logic [SATCNT_W-1:0] sat_cnt
);

  localparam logic [3:0] OpAdd    = 4'd0;
  localparam logic [3:0] OpSub    = 4'd1;
  localparam logic [3:0] OpPaddsb = 4'd2;
  localparam logic [3:0] OpNand   = 4'd3;
  localparam logic [3:0] OpXor    = 4'd4;

  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                out_err_q, out_err_d;
  logic [2:0]          ccr_q, ccr_d;
  logic [SATCNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic legal;
  logic v_touch;  // op defines a new V value
  logic v_val;
  logic accept;

  // Opcode decode: ALU control word and the V-flag rule for each op
  always_comb begin
    legal    = 1'b1;
    v_touch  = 1'b0;
    v_val    = 1'b0;
    alu_Sigs = 4'b0000;
    case (in_op)
      OpAdd: begin
        alu_Sigs = 4'b0100;
        v_touch  = 1'b1;
        v_val    = alu_Vh;
      end
      OpSub: begin
        alu_Sigs = 4'b0101;
        v_touch  = 1'b1;
        v_val    = alu_Vh;
      end
      OpPaddsb: begin
        alu_Sigs = 4'b0110;
        v_touch  = 1'b1;
        v_val    = alu_Vl | alu_Vh;
      end
      OpNand:  alu_Sigs = 4'b1000;
      OpXor:   alu_Sigs = 4'b0000;
      default: legal = 1'b0;
    endcase
  end

  assign alu_A    = in_a;
  assign alu_B    = in_b;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Next state of the output slot, condition codes and saturation counter
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    ccr_d       = ccr_q;
    sat_cnt_d   = sat_cnt_q;
    if (flush) begin
      // Flush beats any completion in the same cycle; the slot simply empties.
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = legal ? alu_D : '0;
      out_err_d   = !legal;
      if (legal) begin
        ccr_d = {alu_Z, alu_N, v_touch ? v_val : ccr_q[0]};
        if (v_touch && v_val && (sat_cnt_q != '1)) begin
          sat_cnt_d = sat_cnt_q + 1'b1;
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      ccr_q       <= 3'b000;
      sat_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      ccr_q       <= ccr_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign ccr       = ccr_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Bench for exec_alu_stage: behavioural ALU on the alu_* port plus a transaction-level
// reference model of the stage, directed steps followed by randomized traffic.
`timescale 1ns/1ps
module tb_exec_alu_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, flush;
  logic [3:0]  in_op;
  logic [15:0] in_a, in_b;
  logic [15:0] alu_A, alu_B, alu_D;
  logic [3:0]  alu_Sigs;
  logic        alu_Vl, alu_Vh, alu_Z, alu_N;
  logic        out_valid, out_ready, out_err;
  logic [15:0] out_data;
  logic [2:0]  ccr;
  logic [7:0]  sat_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_err;
  logic [2:0]  m_ccr;
  int          m_cnt;

  exec_alu_stage #(.W(16), .SATCNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .alu_A(alu_A), .alu_B(alu_B),
    .alu_Sigs(alu_Sigs), .alu_D(alu_D), .alu_Vl(alu_Vl), .alu_Vh(alu_Vh), .alu_Z(alu_Z),
    .alu_N(alu_N), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .ccr(ccr), .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sat8(input int s, output logic v);
    v = 1'b0;
    if (s > 127) begin v = 1'b1; return 8'h7f; end
    if (s < -128) begin v = 1'b1; return 8'h80; end
    return 8'(s);
  endfunction

  // ALU behaviour by operation number: 0 add, 1 sub, 2 paddsb, 3 nand, 4 xor
  function automatic void ref_alu(input int op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic vl, output logic vh);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    vl = 1'b0;
    vh = 1'b0;
    case (op)
      0, 1: begin
        s = (op == 0) ? sa + sb : sa - sb;
        if (s > 32767) begin r = 16'h7fff; vh = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; vh = 1'b1; end
        else r = 16'(s);
      end
      2: begin
        r[7:0]  = sat8(int'($signed(a[7:0])) + int'($signed(b[7:0])), vl);
        r[15:8] = sat8(int'($signed(a[15:8])) + int'($signed(b[15:8])), vh);
      end
      3:       r = ~(a & b);
      default: r = a ^ b;
    endcase
  endfunction

  function automatic int sigs_to_op(input logic [3:0] s);
    case (s)
      4'b0100: return 0;
      4'b0101: return 1;
      4'b0110: return 2;
      4'b1000: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_sigs(input logic [3:0] op);
    case (op)
      4'd0: return 4'b0100;
      4'd1: return 4'b0101;
      4'd2: return 4'b0110;
      4'd3: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Behavioural ALU attached to the stage
  always_comb begin
    alu_D  = '0;
    alu_Vl = 1'b0;
    alu_Vh = 1'b0;
    ref_alu(sigs_to_op(alu_Sigs), alu_A, alu_B, alu_D, alu_Vl, alu_Vh);
    alu_Z = (alu_D == 16'h0000);
    alu_N = alu_D[15];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_ccr   = 3'b000;
    m_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".data"}, 32'(out_data), 32'(m_data));
      chk({tag, ".err"}, 32'(out_err), 32'(m_err));
    end
    chk({tag, ".ccr"}, 32'(ccr), 32'(m_ccr));
    chk({tag, ".sat_cnt"}, 32'(sat_cnt), 32'(m_cnt));
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic ordy, input logic fl);
    logic [15:0] r;
    logic        vl, vh, rdy, acc, legal, vnew;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = !m_valid || ordy;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".sigs"}, 32'(alu_Sigs), 32'(exp_sigs(op)));
    chk({tag, ".alu_ab"}, {alu_A, alu_B}, {a, b});
    ref_alu(int'(op), a, b, r, vl, vh);
    legal = (op <= 4'd4);
    acc   = v && rdy && !fl;
    if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_err   = !legal;
      m_data  = legal ? r : 16'h0000;
      if (legal) begin
        vnew  = (op == 4'd2) ? (vl | vh) : (op <= 4'd1) ? vh : m_ccr[0];
        m_ccr = {r == 16'h0000, r[15], vnew};
        if (op <= 4'd2 && vnew && m_cnt < 255) m_cnt++;
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 1; flush = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(out_valid), 32'h0);
    chk("reset.data", 32'(out_data), 32'h0);
    chk("reset.err", 32'(out_err), 32'h0);
    chk("reset.ccr", 32'(ccr), 32'h0);
    chk("reset.sat_cnt", 32'(sat_cnt), 32'h0);
    rst = 1'b0;

    // Function sweep, no bubbles
    step("sw_add", 1, 4'd0, 16'h2314, 16'h3241, 1, 0);
    chk("sw_add.data", 32'(out_data), 32'h5555);
    step("sw_sub", 1, 4'd1, 16'h2314, 16'h3241, 1, 0);
    chk("sw_sub.data", 32'(out_data), 32'hF0D3);
    chk("sw_sub.ccr", 32'(ccr), 32'b010);
    step("sw_nand", 1, 4'd3, 16'h2314, 16'h3241, 1, 0);
    chk("sw_nand.data", 32'(out_data), 32'hDDFF);
    step("sw_xor", 1, 4'd4, 16'h2314, 16'h3241, 1, 0);
    chk("sw_xor.data", 32'(out_data), 32'h1155);
    chk("sw_xor.ccr", 32'(ccr), 32'b000);
    chk("sw_xor.valid", 32'(out_valid), 32'h1);

    // Saturation
    step("sat_neg", 1, 4'd0, 16'h8032, 16'h8043, 1, 0);
    chk("sat_neg.data", 32'(out_data), 32'h8000);
    chk("sat_neg.ccr", 32'(ccr), 32'b011);
    step("sat_pos", 1, 4'd0, 16'h7F43, 16'h6E43, 1, 0);
    chk("sat_pos.data", 32'(out_data), 32'h7FFF);
    chk("sat_pos.v", 32'(ccr[0]), 32'h1);
    step("sat_pb", 1, 4'd2, 16'h8182, 16'h8182, 1, 0);
    chk("sat_pb.data", 32'(out_data), 32'h8080);
    chk("sat_pb.v", 32'(ccr[0]), 32'h1);
    chk("sat_pb.cnt", 32'(sat_cnt), 32'd3);

    // Zero result with V retained
    step("zero_xor", 1, 4'd4, 16'h0000, 16'h0000, 1, 0);
    chk("zero_xor.data", 32'(out_data), 32'h0000);
    chk("zero_xor.ccr", 32'(ccr), 32'b101);
    chk("zero_xor.cnt", 32'(sat_cnt), 32'd3);

    // Backpressure
    step("bp_add", 1, 4'd0, 16'h2314, 16'h3241, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp_stall", 1, 4'd1, 16'h1111, 16'h0001, 0, 0);
      chk("bp_stall.in_ready", 32'(in_ready), 32'h0);
      chk("bp_stall.data", 32'(out_data), 32'h5555);
    end
    step("bp_release", 1, 4'd1, 16'h1111, 16'h0001, 1, 0);
    chk("bp_release.data", 32'(out_data), 32'h1110);

    // Illegal opcode, then flush while stalled
    step("illegal", 1, 4'd9, 16'h1234, 16'h4321, 1, 0);
    chk("illegal.err", 32'(out_err), 32'h1);
    chk("illegal.data", 32'(out_data), 32'h0000);
    chk("illegal.ccr", 32'(ccr), 32'b000);
    step("flush", 1, 4'd0, 16'h8000, 16'h8000, 0, 1);
    chk("flush.valid", 32'(out_valid), 32'h0);
    chk("flush.ccr", 32'(ccr), 32'b000);
    chk("flush.cnt", 32'(sat_cnt), 32'd3);

    // Async reset during a stall
    step("ar_load", 1, 4'd0, 16'h0001, 16'h0001, 0, 0);
    step("ar_stall", 0, 4'd0, 16'h0000, 16'h0000, 0, 0);
    chk("ar_pre.valid", 32'(out_valid), 32'h1);
    chk("ar_pre.cnt", 32'(sat_cnt), 32'd3);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("ar.valid", 32'(out_valid), 32'h0);
    chk("ar.data", 32'(out_data), 32'h0);
    chk("ar.err", 32'(out_err), 32'h0);
    chk("ar.ccr", 32'(ccr), 32'h0);
    chk("ar.cnt", 32'(sat_cnt), 32'h0);
    #1 rst = 1'b0;
    step("ar_after", 0, 4'd0, 16'h0000, 16'h0000, 1, 0);

    // Counter must stop at its maximum
    for (int i = 0; i < 260; i++) begin
      step("cnt_max", 1, 4'd0, 16'h7FFF, 16'h7FFF, 1, 0);
    end
    chk("cnt_max.final", 32'(sat_cnt), 32'd255);

    // Randomized traffic
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      step("rand", ($urandom_range(0, 3) != 0), op, 16'($urandom), 16'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
